// File: rtl/uart_tx.sv
// uart_tx: buffered 8N1 UART transmitter (LSB first), the status/ack return path.
// Latency: byte written in cycle N is popped in N+1; start bit on tx from N+2.
// Backpressure: ready drops while the byte queue is full; writes while full are
//   dropped and flagged by a one-cycle overflow pulse on the following cycle.
//
// Ports:
//   clk         single clock, rising edge
//   reset       synchronous, active-low
//   data_in     byte to enqueue (sampled only in the accepting cycle)
//   data_valid  write strobe, accepted when data_valid && ready
//   ready       queue not full (decoded from the registered count)
//   tx          registered serial line, idles high
//   busy        a frame is on the line (START/DATA/STOP)
//   fifo_count  bytes waiting, excluding the frame currently being sent
//   overflow    registered pulse: a write was attempted while ready was low

// sync_fifo: circular byte queue with wrapping pointers and a count register.
// Latency: a written entry is visible at the head (and in count) the next cycle.
// Backpressure: full is decoded from count; writes while full are ignored.
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_vld,
  input  logic [W-1:0]            wr_dat,
  input  logic                    rd_en,
  output logic [W-1:0]            rd_dat,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_en;
  logic          rd_go;

  assign full   = (count == FULL_CNT);
  assign wr_en  = wr_vld && !full;
  assign rd_go  = rd_en && (count != '0);
  assign rd_dat = mem[rd_ptr];

  // Storage is not reset: contents are only meaningful behind a nonzero count.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_go) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      // A write and a pop in the same cycle leave the count untouched.
      unique case ({wr_en, rd_go})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// uart_tx: queue front end plus the serializer FSM.
// Latency: see file header; frames run back-to-back with no idle gap.
// Backpressure: ready = queue not full; popping frees a slot immediately.
module uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    data_in,
  input  logic                          data_valid,
  output logic                          ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int BCW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BCW-1:0] BIT_LAST = BCW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t         state_q;
  state_t         state_d;
  logic [BCW-1:0] bit_cnt_q;
  logic [BCW-1:0] bit_cnt_d;
  logic [2:0]     bit_idx_q;
  logic [2:0]     bit_idx_d;
  logic [7:0]     shift_q;
  logic [7:0]     shift_d;
  logic           tx_q;
  logic           tx_d;
  logic           overflow_q;
  logic           pop;
  logic           bit_last;
  logic           fifo_full;
  logic           queued;
  logic [7:0]     head_dat;

  sync_fifo #(
    .W     (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .wr_vld (data_valid),
    .wr_dat (data_in),
    .rd_en  (pop),
    .rd_dat (head_dat),
    .count  (fifo_count),
    .full   (fifo_full)
  );

  assign ready    = !fifo_full;
  assign queued   = (fifo_count != '0);
  assign bit_last = (bit_cnt_q == BIT_LAST);

  // Next-state, pop and next tx level.  tx is registered from the *next*
  // state so the line level always lines up with the state register.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_last ? '0 : bit_cnt_q + BCW'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;

    unique case (state_q)
      IDLE: begin
        bit_cnt_d = '0;
        if (queued) begin
          pop       = 1'b1;
          shift_d   = head_dat;
          bit_idx_d = '0;
          state_d   = START;
        end
      end
      START: begin
        if (bit_last) begin
          bit_idx_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (bit_last) begin
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (bit_last) begin
          // Chain straight into the next start bit when more bytes wait.
          if (queued) begin
            pop       = 1'b1;
            shift_d   = head_dat;
            bit_idx_d = '0;
            state_d   = START;
          end else begin
            state_d   = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      overflow_q <= data_valid && fifo_full;
    end
  end

  assign tx       = tx_q;
  assign busy     = (state_q != IDLE);
  assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int CW    = 3;
  localparam int FRAME = 10 * CPB;

  logic          clk        = 1'b0;
  logic          reset      = 1'b0;
  logic [7:0]    data_in    = 8'h00;
  logic          data_valid = 1'b0;
  logic          ready;
  logic          tx;
  logic          busy;
  logic [CW-1:0] fifo_count;
  logic          overflow;

  uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .data_valid (data_valid),
    .ready      (ready),
    .tx         (tx),
    .busy       (busy),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  // Frame-level view: a queue of waiting bytes, the byte on the line, and the
  // number of cycles left in the current 10-bit frame (0 = line idle).  A new
  // frame may start when the line is idle or in the final cycle of a frame.
  logic [7:0] m_q[$];
  logic [7:0] m_cur   = 8'h00;
  int         m_count = 0;
  int         m_left  = 0;
  bit         m_ovf   = 1'b0;
  bit         m_acc;
  bit         m_pop;

  always @(posedge clk) begin
    if (!reset) begin
      m_q.delete();
      m_count = 0;
      m_left  = 0;
      m_ovf   = 1'b0;
    end else begin
      m_acc = data_valid && (m_count != DEPTH);
      m_pop = (m_count > 0) && (m_left <= 1);
      m_ovf = data_valid && (m_count == DEPTH);
      if (m_pop) m_cur = m_q.pop_front();
      if (m_acc) m_q.push_back(data_in);
      m_left  = m_pop ? FRAME : ((m_left > 0) ? m_left - 1 : 0);
      m_count = m_count + int'(m_acc) - int'(m_pop);
    end
  end

  function automatic logic exp_tx();
    int pos;
    if (m_left == 0) return 1'b1;
    pos = (FRAME - m_left) / CPB;   // 0 = start, 1..8 = data bits, 9 = stop
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return m_cur[pos-1];
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("mdl_tx",         tx,         exp_tx());
      chk("mdl_busy",       busy,       m_left != 0);
      chk("mdl_fifo_count", fifo_count, m_count);
      chk("mdl_ready",      ready,      m_count != DEPTH);
      chk("mdl_overflow",   overflow,   m_ovf);
    end
  end

  task automatic wait_idle(input int max, input string name);
    int i = 0;
    while (busy !== 1'b0 && i < max) begin
      step(1);
      i++;
    end
    chk(name, busy, 1'b0);
  endtask

  task automatic write_byte(input logic [7:0] b);
    data_in    = b;
    data_valid = 1'b1;
    step(1);
    data_valid = 1'b0;
    data_in    = 8'($urandom);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [7:0] dat;
    logic [9:0] frame;  // line bits in time order, bit 0 = start bit
  } vec_t;

  vec_t       vecs[4];
  logic [7:0] b2b[3];
  int         t0;

  initial begin
    vecs[0] = '{dat: 8'hA5, frame: 10'b1101001010};
    vecs[1] = '{dat: 8'h00, frame: 10'b1000000000};
    vecs[2] = '{dat: 8'hFF, frame: 10'b1111111110};
    vecs[3] = '{dat: 8'h3C, frame: 10'b1001111000};
    b2b[0] = 8'h00;
    b2b[1] = 8'hFF;
    b2b[2] = 8'h3C;

    // Reset state
    reset = 1'b0;
    step(3);
    chk_en = 1'b1;
    chk("rst_tx",       tx,         1'b1);
    chk("rst_busy",     busy,       1'b0);
    chk("rst_count",    fifo_count, 3'd0);
    chk("rst_ready",    ready,      1'b1);
    chk("rst_overflow", overflow,   1'b0);
    reset = 1'b1;
    step(2);

    // Single frames: exact latency and bit-cell contents
    for (int v = 0; v < 4; v++) begin
      write_byte(vecs[v].dat);                        // now cycle N+1
      chk("lat_count_n1", fifo_count, 3'd1);
      chk("lat_busy_n1",  busy,       1'b0);
      step(1);                                         // N+2
      chk("lat_count_n2", fifo_count, 3'd0);
      chk("lat_busy_n2",  busy,       1'b1);
      chk("lat_tx_n2",    tx,         1'b0);
      for (int k = 0; k < 10; k++) begin
        step((k == 0) ? 1 : CPB);                      // mid-cell of bit k
        chk("frame_bit", tx, vecs[v].frame[k]);
      end
      step(2);                                         // N+41, last stop cycle
      chk("busy_last_stop", busy, 1'b1);
      step(1);                                         // N+42
      chk("busy_fall", busy, 1'b0);
      chk("idle_tx",   tx,   1'b1);
      step(3);
    end

    // Back-to-back frames written on consecutive cycles
    t0 = cyc;
    for (int i = 0; i < 3; i++) begin
      data_in    = b2b[i];
      data_valid = 1'b1;
      step(1);
    end
    data_valid = 1'b0;
    wait_idle(4 * FRAME, "b2b_timeout");
    chk("b2b_len", cyc - t0, 2 + 3 * FRAME);
    step(2);

    // Burst of 6 while idle: one pops, four fill, sixth dropped
    t0 = cyc;
    for (int i = 0; i < 6; i++) begin
      data_in    = 8'($urandom);
      data_valid = 1'b1;
      if (i == 4) chk("burst_ready_n4", ready, 1'b1);
      if (i == 5) chk("burst_ready_full", ready, 1'b0);
      step(1);
    end
    data_valid = 1'b0;
    chk("burst_ovf", overflow, 1'b1);
    step(1);
    chk("burst_ovf_once", overflow, 1'b0);
    wait_idle(6 * FRAME, "burst_timeout");
    chk("burst_len", cyc - t0, 2 + 5 * FRAME);
    step(2);

    // Full queue: write in the cycle right after a STOP->START pop
    for (int i = 0; i < 5; i++) begin
      data_in    = 8'($urandom);
      data_valid = 1'b1;
      step(1);
    end
    data_valid = 1'b0;
    chk("full_count", fifo_count, 3'd4);
    for (int i = 0; i < 2 * FRAME && fifo_count == 3'd4; i++) step(1);
    chk("pop_seen", fifo_count, 3'd3);
    write_byte(8'h5A);
    chk("refill_count", fifo_count, 3'd4);
    chk("refill_ready", ready,      1'b0);
    chk("refill_no_ovf", overflow,  1'b0);
    wait_idle(6 * FRAME, "refill_timeout");
    step(2);

    // Reset in the DATA phase of the 2nd of 3 queued frames
    for (int i = 0; i < 3; i++) begin
      data_in    = 8'($urandom);
      data_valid = 1'b1;
      step(1);
    end
    data_valid = 1'b0;                                  // now N+3
    step(52);                                           // N+55
    chk("pre_reset_busy",  busy,       1'b1);
    chk("pre_reset_count", fifo_count, 3'd1);
    reset = 1'b0;
    step(1);
    chk("midrst_tx",    tx,         1'b1);
    chk("midrst_busy",  busy,       1'b0);
    chk("midrst_count", fifo_count, 3'd0);
    chk("midrst_ready", ready,      1'b1);
    step(2);
    reset = 1'b1;
    step(2 * FRAME);
    chk("no_frames_after_reset", busy, 1'b0);

    // Pointer wrap: 20 bytes trickled in whenever there is room
    for (int i = 0; i < 20; i++) begin
      step($urandom_range(0, 50));
      for (int w = 0; w < 2 * FRAME && ready !== 1'b1; w++) step(1);
      chk("wrap_ready", ready, 1'b1);
      write_byte(8'(i));
    end
    wait_idle(30 * FRAME, "wrap_timeout");
    chk("wrap_drained", fifo_count, 3'd0);

    // Randomized traffic including writes while full and rare resets
    for (int i = 0; i < 1500; i++) begin
      data_valid = ($urandom_range(0, 9) < 3);
      data_in    = 8'($urandom);
      reset      = ($urandom_range(0, 499) != 0);
      step(1);
    end
    data_valid = 1'b0;
    reset      = 1'b1;
    wait_idle((DEPTH + 2) * FRAME, "rand_timeout");
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
